// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: hour/minute/second timekeeping with a three-state
// time-setting mode driven by two debounced keys. It also produces a
// registered active-low clear for the seconds divider.
module clock_time_ctrl #(
    parameter int H_MOD = 24,
    parameter int M_MOD = 60
) (
    input  logic       CLK_50M,
    input  logic       nCLR,
    input  logic       TICK,
    input  logic       KEY_MODE,
    input  logic       KEY_INC,
    output logic [4:0] HOUR,
    output logic [5:0] MIN,
    output logic [5:0] SEC,
    output logic [1:0] MODE,
    output logic       DIV_nCLR,
    output logic       DAY
);

    localparam logic [4:0] H_MAX = 5'(H_MOD - 1);
    localparam logic [5:0] M_MAX = 6'(M_MOD - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } state_t;

    // Wrapping increment; compares first so no stored value ever reaches the modulus.
    function automatic logic [4:0] incWrap5(input logic [4:0] value, input logic [4:0] maxValue);
        if (value >= maxValue) begin
            return 5'd0;
        end else begin
            return value + 5'd1;
        end
    endfunction

    function automatic logic [5:0] incWrap6(input logic [5:0] value, input logic [5:0] maxValue);
        if (value >= maxValue) begin
            return 6'd0;
        end else begin
            return value + 6'd1;
        end
    endfunction

    state_t     state_r;
    state_t     nextState_s;
    logic       tickPrev_r;
    logic       modePrev_r;
    logic       incPrev_r;
    logic       tickEv_s;
    logic       modeEv_s;
    logic       incEv_s;
    logic [4:0] hour_r;
    logic [5:0] min_r;
    logic [5:0] sec_r;
    logic       day_r;
    logic       divNclr_r;
    logic [4:0] hourNext_s;
    logic [5:0] minNext_s;
    logic [5:0] secNext_s;
    logic       dayNext_s;
    logic       divNclrNext_s;

    // Prev registers reset high, so a level held across reset release is not an event.
    assign tickEv_s = TICK     & ~tickPrev_r;
    assign modeEv_s = KEY_MODE & ~modePrev_r;
    assign incEv_s  = KEY_INC  & ~incPrev_r;

    // Edge-detect history for the three synchronous inputs.
    always_ff @(posedge CLK_50M) begin
        if (!nCLR) begin
            tickPrev_r <= 1'b1;
            modePrev_r <= 1'b1;
            incPrev_r  <= 1'b1;
        end else begin
            tickPrev_r <= TICK;
            modePrev_r <= KEY_MODE;
            incPrev_r  <= KEY_INC;
        end
    end

    // Mode state register.
    always_ff @(posedge CLK_50M) begin
        if (!nCLR) begin
            state_r <= RUN;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Mode key cycles RUN -> SET_H -> SET_M -> RUN.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            RUN:     if (modeEv_s) nextState_s = SET_H; else nextState_s = RUN;
            SET_H:   if (modeEv_s) nextState_s = SET_M; else nextState_s = SET_H;
            SET_M:   if (modeEv_s) nextState_s = RUN;   else nextState_s = SET_M;
            default: nextState_s = RUN;
        endcase
    end

    // Divider runs only while the next state is RUN; registered to align with MODE.
    always_comb begin
        divNclrNext_s = 1'b0;
        if (nextState_s == RUN) begin
            divNclrNext_s = 1'b1;
        end else begin
            divNclrNext_s = 1'b0;
        end
    end

    // Counter update: full carry chain in RUN, carry-free setting in SET_H/SET_M.
    // A mode event in the same cycle as an increment event discards the increment.
    always_comb begin
        hourNext_s = hour_r;
        minNext_s  = min_r;
        secNext_s  = sec_r;
        dayNext_s  = 1'b0;
        case (state_r)
            RUN: begin
                if (tickEv_s) begin
                    secNext_s = incWrap6(sec_r, M_MAX);
                    if (sec_r >= M_MAX) begin
                        minNext_s = incWrap6(min_r, M_MAX);
                        if (min_r >= M_MAX) begin
                            hourNext_s = incWrap5(hour_r, H_MAX);
                            if (hour_r >= H_MAX) begin
                                dayNext_s = 1'b1;
                            end else begin
                                dayNext_s = 1'b0;
                            end
                        end else begin
                            hourNext_s = hour_r;
                        end
                    end else begin
                        minNext_s = min_r;
                    end
                end else begin
                    secNext_s = sec_r;
                end
            end
            SET_H: begin
                if (incEv_s && !modeEv_s) begin
                    hourNext_s = incWrap5(hour_r, H_MAX);
                end else begin
                    hourNext_s = hour_r;
                end
            end
            SET_M: begin
                if (modeEv_s) begin
                    secNext_s = 6'd0;
                end else if (incEv_s) begin
                    minNext_s = incWrap6(min_r, M_MAX);
                end else begin
                    minNext_s = min_r;
                end
            end
            default: begin
                hourNext_s = hour_r;
            end
        endcase
    end

    // Registered counters, day pulse and divider clear.
    always_ff @(posedge CLK_50M) begin
        if (!nCLR) begin
            hour_r    <= 5'd0;
            min_r     <= 6'd0;
            sec_r     <= 6'd0;
            day_r     <= 1'b0;
            divNclr_r <= 1'b0;
        end else begin
            hour_r    <= hourNext_s;
            min_r     <= minNext_s;
            sec_r     <= secNext_s;
            day_r     <= dayNext_s;
            divNclr_r <= divNclrNext_s;
        end
    end

    assign HOUR     = hour_r;
    assign MIN      = min_r;
    assign SEC      = sec_r;
    assign MODE     = state_r;
    assign DAY      = day_r;
    assign DIV_nCLR = divNclr_r;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Testbench for clock_time_ctrl: directed scenarios followed by random
// stimulus, all outputs checked each cycle against a time-in-seconds model.
module tb_clock_time_ctrl;

    localparam int H_MOD = 24;
    localparam int M_MOD = 60;
    localparam int DAY_SECS = H_MOD * M_MOD * M_MOD;

    logic       CLK_50M = 1'b0;
    logic       nCLR = 1'b0;
    logic       TICK = 1'b0;
    logic       KEY_MODE = 1'b0;
    logic       KEY_INC = 1'b0;
    logic [4:0] HOUR;
    logic [5:0] MIN;
    logic [5:0] SEC;
    logic [1:0] MODE;
    logic       DIV_nCLR;
    logic       DAY;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    int mh, mm, ms, mmode;
    bit mday, mdiv;
    bit pT, pM, pI;

    clock_time_ctrl #(.H_MOD(H_MOD), .M_MOD(M_MOD)) dut (
        .CLK_50M (CLK_50M),
        .nCLR    (nCLR),
        .TICK    (TICK),
        .KEY_MODE(KEY_MODE),
        .KEY_INC (KEY_INC),
        .HOUR    (HOUR),
        .MIN     (MIN),
        .SEC     (SEC),
        .MODE    (MODE),
        .DIV_nCLR(DIV_nCLR),
        .DAY     (DAY)
    );

    always #10 CLK_50M = ~CLK_50M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference model, from the inputs sampled at that edge.
    task automatic modelEdge();
        bit evT, evM, evI;
        int total;
        if (!nCLR) begin
            mh = 0; mm = 0; ms = 0; mmode = 0;
            mday = 0; mdiv = 0;
            pT = 1; pM = 1; pI = 1;
        end else begin
            evT = TICK && !pT;
            evM = KEY_MODE && !pM;
            evI = KEY_INC && !pI;
            mday = 0;
            if (mmode == 0 && evT) begin
                total = (mh * M_MOD * M_MOD + mm * M_MOD + ms + 1) % DAY_SECS;
                mday = (total == 0);
                mh = total / (M_MOD * M_MOD);
                mm = (total / M_MOD) % M_MOD;
                ms = total % M_MOD;
            end
            if (mmode == 1 && evI && !evM) mh = (mh + 1) % H_MOD;
            if (mmode == 2 && evI && !evM) mm = (mm + 1) % M_MOD;
            if (evM) begin
                if (mmode == 2) ms = 0;
                mmode = (mmode + 1) % 3;
            end
            mdiv = (mmode == 0);
            pT = TICK; pM = KEY_MODE; pI = KEY_INC;
        end
    endtask

    task automatic checkAll();
        chk("HOUR", 32'(HOUR), 32'(mh));
        chk("MIN", 32'(MIN), 32'(mm));
        chk("SEC", 32'(SEC), 32'(ms));
        chk("MODE", 32'(MODE), 32'(mmode));
        chk("DAY", 32'(DAY), 32'(mday));
        chk("DIV_nCLR", 32'(DIV_nCLR), 32'(mdiv));
    endtask

    task automatic step(input logic r, input logic t, input logic m, input logic i);
        nCLR = r; TICK = t; KEY_MODE = m; KEY_INC = i;
        @(posedge CLK_50M);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic tickPulse();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic incPulse();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic modePulse();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        mh = 0; mm = 0; ms = 0; mmode = 0;
        mday = 0; mdiv = 0; pT = 1; pM = 1; pI = 1;

        // Reset with all inputs high, then release while still high
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("rst_div", 32'(DIV_nCLR), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rel_div", 32'(DIV_nCLR), 32'd1);
        chk("rel_sec", 32'(SEC), 32'd0);
        chk("rel_mode", 32'(MODE), 32'd0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Preload 23:59:58
        modePulse();
        for (int k = 0; k < 23; k++) incPulse();
        modePulse();
        for (int k = 0; k < 59; k++) incPulse();
        modePulse();
        for (int k = 0; k < 58; k++) tickPulse();
        chk("pre_time", {HOUR, MIN, SEC}, {5'd23, 6'd59, 6'd58});
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sec59", 32'(SEC), 32'd59);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("day_pulse", 32'(DAY), 32'd1);
        chk("roll_time", {HOUR, MIN, SEC}, 17'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("day_once", 32'(DAY), 32'd0);

        // 59 ticks, one more carries into MIN, held TICK counts once
        for (int k = 0; k < 59; k++) tickPulse();
        chk("s59_m0", {MIN, SEC}, {6'd0, 6'd59});
        tickPulse();
        chk("s0_m1", {MIN, SEC}, {6'd1, 6'd0});
        for (int k = 0; k < 100; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("held_tick", 32'(SEC), 32'd1);

        // SET_H: 25 increments wrap to 1, ticks ignored
        modePulse();
        for (int k = 0; k < 25; k++) begin
            incPulse();
            tickPulse();
        end
        chk("seth_hour", 32'(HOUR), 32'd1);
        chk("seth_mode", 32'(MODE), 32'd1);
        chk("seth_div", 32'(DIV_nCLR), 32'd0);
        chk("seth_ms", {MIN, SEC}, {6'd1, 6'd1});

        // SET_M: 61 increments, then back to RUN clears SEC
        modePulse();
        for (int k = 0; k < 61; k++) incPulse();
        chk("setm_min", 32'(MIN), 32'd2);
        chk("setm_hour", 32'(HOUR), 32'd1);
        modePulse();
        chk("run_sec0", 32'(SEC), 32'd0);
        chk("run_div", 32'(DIV_nCLR), 32'd1);

        // Mode and inc together in SET_H, then reset mid SET_M
        modePulse();
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("both_mode", 32'(MODE), 32'd2);
        chk("both_hour", 32'(HOUR), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        incPulse();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("midrst", {HOUR, MIN, SEC, MODE, DIV_nCLR, DAY}, 21'd0);

        // Tick and mode in the same RUN cycle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("tickmode_sec", 32'(SEC), 32'd1);
        chk("tickmode_mode", 32'(MODE), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        modePulse();
        modePulse();

        // Random stimulus against the model
        for (int k = 0; k < 4000; k++) begin
            step(logic'($urandom_range(0, 299) != 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 11) == 0),
                 logic'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
